branch_predictor_unit: RTL and testbench

- Parametrised branch prediction and resolution unit for the next-generation pipelined core.
- Replaces the fixed predict-not-taken, flush-at-MEM scheme with a bimodal saturating-counter table plus a direct-mapped BTB.
- Fetch queries it combinationally each cycle. The MEM stage reports resolved control transfers; the unit updates state and raises flush/redirect/mispredict.

---
 rtl/branch_predictor_unit_if.sv | 43 ++++
 rtl/branch_predictor_unit.sv | 125 ++++++++++++
 tb/tb_branch_predictor_unit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_unit_if.sv
// ============================================================================
// Module : branch_predictor_unit_if
// Brief  : Fetch-lookup and MEM-resolution bus of the branch predictor unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface branch_predictor_unit_if #(
    parameter int PC_W = 32
);
    logic [PC_W-1:0] i_fetch_pc;
    logic            o_pred_taken;
    logic [PC_W-1:0] o_pred_target;
    logic            i_res_vld;
    logic            i_res_ctrl;
    logic            i_res_uncond;
    logic [PC_W-1:0] i_res_pc;
    logic            i_res_taken;
    logic [PC_W-1:0] i_res_target;
    logic            i_res_pred_taken;
    logic [PC_W-1:0] i_res_pred_target;
    logic            o_flush;
    logic [PC_W-1:0] o_redirect_pc;
    logic            o_mispred;
    logic [31:0]     o_br_count;
    logic [31:0]     o_mispred_count;

    modport master (
        output i_fetch_pc, i_res_vld, i_res_ctrl, i_res_uncond, i_res_pc,
               i_res_taken, i_res_target, i_res_pred_taken, i_res_pred_target,
        input  o_pred_taken, o_pred_target, o_flush, o_redirect_pc, o_mispred,
               o_br_count, o_mispred_count
    );

    modport slave (
        input  i_fetch_pc, i_res_vld, i_res_ctrl, i_res_uncond, i_res_pc,
               i_res_taken, i_res_target, i_res_pred_taken, i_res_pred_target,
        output o_pred_taken, o_pred_target, o_flush, o_redirect_pc, o_mispred,
               o_br_count, o_mispred_count
    );
endinterface

`default_nettype wire

// File: rtl/branch_predictor_unit.sv
// ============================================================================
// Module : branch_predictor_unit
// Brief  : Bimodal counter table + direct-mapped BTB with MEM-stage resolution.
//          Optional perf counters: define BRANCH_PREDICTOR_PERF_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_predictor_unit #(
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 2,
    parameter int PC_W        = 32,
    parameter int MODE        = 1
) (
    input  wire logic             i_clk,
    input  wire logic             i_reset,
    branch_predictor_unit_if.slave bus
);
    localparam int              c_IDX_W    = $clog2(BHT_ENTRIES);
    localparam int              c_TAG_W    = PC_W - c_IDX_W - 2;
    localparam logic [CNT_W-1:0] c_CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    logic [CNT_W-1:0]   cnt_q    [BHT_ENTRIES];
    logic               valid_q  [BHT_ENTRIES];
    logic [c_TAG_W-1:0] tag_q    [BHT_ENTRIES];
    logic [PC_W-1:0]    target_q [BHT_ENTRIES];
    logic               mispred_q;

    logic [c_IDX_W-1:0] w_f_idx;
    logic [c_TAG_W-1:0] w_f_tag;
    logic               w_hit;
    logic               w_pred_taken;
    logic [c_IDX_W-1:0] w_r_idx;
    logic [c_TAG_W-1:0] w_r_tag;
    logic [CNT_W-1:0]   w_cnt_cur;
    logic [CNT_W-1:0]   cnt_d;
    logic [PC_W-1:0]    w_res_seq;
    logic [PC_W-1:0]    w_actual_next;
    logic               w_flush;
    logic               w_upd;

    assign w_f_idx      = bus.i_fetch_pc[c_IDX_W+1:2];
    assign w_f_tag      = bus.i_fetch_pc[PC_W-1:c_IDX_W+2];
    assign w_hit        = valid_q[w_f_idx] && (tag_q[w_f_idx] == w_f_tag);
    assign w_pred_taken = (MODE == 1) && w_hit && cnt_q[w_f_idx][CNT_W-1];

    assign bus.o_pred_taken  = w_pred_taken;
    assign bus.o_pred_target = w_pred_taken ? target_q[w_f_idx]
                                            : bus.i_fetch_pc + PC_W'(4);

    // Non-control instructions also flush on a stale target left by BTB aliasing.
    assign w_res_seq     = bus.i_res_pc + PC_W'(4);
    assign w_actual_next = bus.i_res_taken ? bus.i_res_target : w_res_seq;
    assign w_flush       = bus.i_res_vld && (w_actual_next != bus.i_res_pred_target);

    assign bus.o_flush       = w_flush;
    assign bus.o_redirect_pc = w_flush ? w_actual_next : '0;
    assign bus.o_mispred     = mispred_q;

    assign w_upd     = (MODE == 1) && bus.i_res_vld && bus.i_res_ctrl;
    assign w_r_idx   = bus.i_res_pc[c_IDX_W+1:2];
    assign w_r_tag   = bus.i_res_pc[PC_W-1:c_IDX_W+2];
    assign w_cnt_cur = cnt_q[w_r_idx];

    always_comb begin
        cnt_d = w_cnt_cur;
        if (bus.i_res_uncond) begin
            cnt_d = c_CNT_MAX;
        end else if (bus.i_res_taken) begin
            if (w_cnt_cur != c_CNT_MAX) cnt_d = w_cnt_cur + CNT_W'(1);
        end else begin
            if (w_cnt_cur != '0) cnt_d = w_cnt_cur - CNT_W'(1);
        end
    end

    // The counter trains even on a tag mismatch; only taken outcomes claim the BTB slot.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                cnt_q[i]    <= c_CNT_INIT;
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
            mispred_q <= 1'b0;
        end else begin
            mispred_q <= w_flush;
            if (w_upd) begin
                cnt_q[w_r_idx] <= cnt_d;
                if (bus.i_res_taken) begin
                    valid_q[w_r_idx]  <= 1'b1;
                    tag_q[w_r_idx]    <= w_r_tag;
                    target_q[w_r_idx] <= bus.i_res_target;
                end
            end
        end
    end

`ifdef BRANCH_PREDICTOR_PERF_CNT_EN
    logic [31:0] br_cnt_q;
    logic [31:0] mp_cnt_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            if (bus.i_res_vld && bus.i_res_ctrl && (br_cnt_q != 32'hFFFF_FFFF))
                br_cnt_q <= br_cnt_q + 32'd1;
            if (w_flush && (mp_cnt_q != 32'hFFFF_FFFF))
                mp_cnt_q <= mp_cnt_q + 32'd1;
        end
    end

    assign bus.o_br_count      = br_cnt_q;
    assign bus.o_mispred_count = mp_cnt_q;
`else
    assign bus.o_br_count      = 32'd0;
    assign bus.o_mispred_count = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor_unit.sv
// ============================================================================
// Module : tb_branch_predictor_unit
// Brief  : Directed self-checking bench for branch_predictor_unit (MODE 1 and 0).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor_unit;
    logic i_clk   = 1'b0;
    logic i_reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 i_clk = ~i_clk;

    branch_predictor_unit_if #(.PC_W(32)) bus1 ();
    branch_predictor_unit_if #(.PC_W(32)) bus0 ();

    branch_predictor_unit #(.BHT_ENTRIES(64), .CNT_W(2), .PC_W(32), .MODE(1)) u_dut1 (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus1)
    );

    branch_predictor_unit #(.BHT_ENTRIES(64), .CNT_W(2), .PC_W(32), .MODE(0)) u_dut0 (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus0)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic set_fetch(input logic [31:0] pc);
        bus1.i_fetch_pc = pc;
        bus0.i_fetch_pc = pc;
        #1;
    endtask

    task automatic set_res(input logic [31:0] pc, input logic ctrl, input logic uncond,
                           input logic taken, input logic [31:0] tgt,
                           input logic ptaken, input logic [31:0] ptgt);
        bus1.i_res_vld = 1'b1;         bus0.i_res_vld = 1'b1;
        bus1.i_res_ctrl = ctrl;        bus0.i_res_ctrl = ctrl;
        bus1.i_res_uncond = uncond;    bus0.i_res_uncond = uncond;
        bus1.i_res_pc = pc;            bus0.i_res_pc = pc;
        bus1.i_res_taken = taken;      bus0.i_res_taken = taken;
        bus1.i_res_target = tgt;       bus0.i_res_target = tgt;
        bus1.i_res_pred_taken = ptaken; bus0.i_res_pred_taken = ptaken;
        bus1.i_res_pred_target = ptgt; bus0.i_res_pred_target = ptgt;
        #1;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        bus1.i_res_vld = 1'b0;
        bus0.i_res_vld = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        set_res(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h4);
        bus1.i_res_vld = 1'b0; bus0.i_res_vld = 1'b0;
        set_fetch(32'h100);
        n_tests++; if (bus1.o_pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred_taken: got %0h want 0", bus1.o_pred_taken); end
        n_tests++; if (bus1.o_pred_target !== 32'h104) begin n_fail++; $display("FAIL reset_pred_target: got %h want 00000104", bus1.o_pred_target); end
        n_tests++; if (bus1.o_flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %0h want 0", bus1.o_flush); end
        n_tests++; if (bus1.o_redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_redirect: got %h want 0", bus1.o_redirect_pc); end
        n_tests++; if (bus1.o_mispred !== 1'b0) begin n_fail++; $display("FAIL reset_mispred: got %0h want 0", bus1.o_mispred); end
        n_tests++; if (bus1.o_br_count !== 32'd0 || bus1.o_mispred_count !== 32'd0) begin n_fail++; $display("FAIL reset_perf: got %0d/%0d want 0/0", bus1.o_br_count, bus1.o_mispred_count); end
        @(negedge i_clk);
        i_reset = 1'b1;
        #1;
    endtask

    task automatic test_train_taken();
        set_fetch(32'h100);
        set_res(32'h100, 1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'h104);
        n_tests++; if (bus1.o_flush !== 1'b1) begin n_fail++; $display("FAIL train_flush: got %0h want 1", bus1.o_flush); end
        n_tests++; if (bus1.o_redirect_pc !== 32'h40) begin n_fail++; $display("FAIL train_redirect: got %h want 00000040", bus1.o_redirect_pc); end
        n_tests++; if (bus1.o_mispred !== 1'b0) begin n_fail++; $display("FAIL train_mispred_early: got %0h want 0", bus1.o_mispred); end
        tick();
        n_tests++; if (bus1.o_mispred !== 1'b1) begin n_fail++; $display("FAIL train_mispred_late: got %0h want 1", bus1.o_mispred); end
        n_tests++; if (bus1.o_pred_taken !== 1'b1) begin n_fail++; $display("FAIL train_pred_taken: got %0h want 1", bus1.o_pred_taken); end
        n_tests++; if (bus1.o_pred_target !== 32'h40) begin n_fail++; $display("FAIL train_pred_target: got %h want 00000040", bus1.o_pred_target); end
        tick();
        n_tests++; if (bus1.o_mispred !== 1'b0) begin n_fail++; $display("FAIL train_mispred_clear: got %0h want 0", bus1.o_mispred); end
    endtask

    task automatic test_counter();
        for (int i = 0; i < 2; i++) begin
            set_res(32'h100, 1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'h40);
            n_tests++; if (bus1.o_flush !== 1'b0) begin n_fail++; $display("FAIL cnt_correct_flush: got %0h want 0 (iter %0d)", bus1.o_flush, i); end
            tick();
        end
        set_res(32'h100, 1'b1, 1'b0, 1'b0, 32'h40, 1'b1, 32'h40);
        n_tests++; if (bus1.o_flush !== 1'b1 || bus1.o_redirect_pc !== 32'h104) begin n_fail++; $display("FAIL cnt_nt1_flush: got %0h/%h want 1/00000104", bus1.o_flush, bus1.o_redirect_pc); end
        tick();
        n_tests++; if (bus1.o_pred_taken !== 1'b1 || bus1.o_pred_target !== 32'h40) begin n_fail++; $display("FAIL cnt_after_nt1: got %0h/%h want 1/00000040", bus1.o_pred_taken, bus1.o_pred_target); end
        set_res(32'h100, 1'b1, 1'b0, 1'b0, 32'h40, 1'b1, 32'h40);
        n_tests++; if (bus1.o_pred_taken !== 1'b1) begin n_fail++; $display("FAIL cnt_no_bypass: got %0h want 1", bus1.o_pred_taken); end
        tick();
        n_tests++; if (bus1.o_pred_taken !== 1'b0 || bus1.o_pred_target !== 32'h104) begin n_fail++; $display("FAIL cnt_after_nt2: got %0h/%h want 0/00000104", bus1.o_pred_taken, bus1.o_pred_target); end
    endtask

    task automatic test_alias();
        set_res(32'h100, 1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'h104);
        tick();
        n_tests++; if (bus1.o_pred_taken !== 1'b1) begin n_fail++; $display("FAIL alias_retrain: got %0h want 1", bus1.o_pred_taken); end
        set_fetch(32'h200);
        n_tests++; if (bus1.o_pred_taken !== 1'b0 || bus1.o_pred_target !== 32'h204) begin n_fail++; $display("FAIL alias_miss: got %0h/%h want 0/00000204", bus1.o_pred_taken, bus1.o_pred_target); end
        set_res(32'h200, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h204);
        n_tests++; if (bus1.o_flush !== 1'b1 || bus1.o_redirect_pc !== 32'h80) begin n_fail++; $display("FAIL alias_flush: got %0h/%h want 1/00000080", bus1.o_flush, bus1.o_redirect_pc); end
        tick();
        n_tests++; if (bus1.o_pred_taken !== 1'b1 || bus1.o_pred_target !== 32'h80) begin n_fail++; $display("FAIL alias_retag_hit: got %0h/%h want 1/00000080", bus1.o_pred_taken, bus1.o_pred_target); end
        set_fetch(32'h100);
        n_tests++; if (bus1.o_pred_taken !== 1'b0 || bus1.o_pred_target !== 32'h104) begin n_fail++; $display("FAIL alias_old_miss: got %0h/%h want 0/00000104", bus1.o_pred_taken, bus1.o_pred_target); end
        set_res(32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h104);
        n_tests++; if (bus1.o_flush !== 1'b0) begin n_fail++; $display("FAIL alias_nt_flush: got %0h want 0", bus1.o_flush); end
        tick();
        set_fetch(32'h200);
        n_tests++; if (bus1.o_pred_taken !== 1'b1 || bus1.o_pred_target !== 32'h80) begin n_fail++; $display("FAIL alias_btb_kept: got %0h/%h want 1/00000080", bus1.o_pred_taken, bus1.o_pred_target); end
    endtask

    task automatic test_uncond();
        set_fetch(32'h10C);
        set_res(32'h10C, 1'b1, 1'b1, 1'b1, 32'h500, 1'b0, 32'h110);
        n_tests++; if (bus1.o_flush !== 1'b1 || bus1.o_redirect_pc !== 32'h500) begin n_fail++; $display("FAIL uncond_flush: got %0h/%h want 1/00000500", bus1.o_flush, bus1.o_redirect_pc); end
        tick();
        n_tests++; if (bus1.o_pred_taken !== 1'b1 || bus1.o_pred_target !== 32'h500) begin n_fail++; $display("FAIL uncond_pred: got %0h/%h want 1/00000500", bus1.o_pred_taken, bus1.o_pred_target); end
        set_res(32'h10C, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h500);
        n_tests++; if (bus1.o_redirect_pc !== 32'h110) begin n_fail++; $display("FAIL uncond_nt_redirect: got %h want 00000110", bus1.o_redirect_pc); end
        tick();
        n_tests++; if (bus1.o_pred_taken !== 1'b1) begin n_fail++; $display("FAIL uncond_max_cnt: got %0h want 1", bus1.o_pred_taken); end
    endtask

    task automatic test_nonctrl();
        set_fetch(32'h20);
        set_res(32'h20, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h80);
        n_tests++; if (bus1.o_flush !== 1'b1 || bus1.o_redirect_pc !== 32'h24) begin n_fail++; $display("FAIL nonctrl_flush: got %0h/%h want 1/00000024", bus1.o_flush, bus1.o_redirect_pc); end
        tick();
        set_res(32'h20, 1'b0, 1'b0, 1'b1, 32'h30, 1'b0, 32'h30);
        tick();
        n_tests++; if (bus1.o_pred_taken !== 1'b0 || bus1.o_pred_target !== 32'h24) begin n_fail++; $display("FAIL nonctrl_no_update: got %0h/%h want 0/00000024", bus1.o_pred_taken, bus1.o_pred_target); end
        set_res(32'h20, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h24);
        n_tests++; if (bus1.o_flush !== 1'b0 || bus1.o_redirect_pc !== 32'h0) begin n_fail++; $display("FAIL nonctrl_seq: got %0h/%h want 0/00000000", bus1.o_flush, bus1.o_redirect_pc); end
        tick();
        bus1.i_res_pred_target = 32'h999;
        #1;
        n_tests++; if (bus1.o_flush !== 1'b0 || bus1.o_redirect_pc !== 32'h0) begin n_fail++; $display("FAIL novld_flush: got %0h/%h want 0/00000000", bus1.o_flush, bus1.o_redirect_pc); end
        set_fetch(32'hFFFF_FFFC);
        n_tests++; if (bus1.o_pred_taken !== 1'b0 || bus1.o_pred_target !== 32'h0) begin n_fail++; $display("FAIL wrap_target: got %0h/%h want 0/00000000", bus1.o_pred_taken, bus1.o_pred_target); end
    endtask

    task automatic test_mode0();
        set_fetch(32'h100);
        for (int i = 0; i < 5; i++) begin
            set_res(32'h100, 1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'h104);
            n_tests++; if (bus0.o_flush !== 1'b1 || bus0.o_redirect_pc !== 32'h40) begin n_fail++; $display("FAIL mode0_flush: got %0h/%h want 1/00000040 (iter %0d)", bus0.o_flush, bus0.o_redirect_pc, i); end
            tick();
            n_tests++; if (bus0.o_pred_taken !== 1'b0 || bus0.o_pred_target !== 32'h104) begin n_fail++; $display("FAIL mode0_pred: got %0h/%h want 0/00000104 (iter %0d)", bus0.o_pred_taken, bus0.o_pred_target, i); end
        end
    endtask

    task automatic test_perf();
        logic [31:0] exp_br;
        logic [31:0] exp_mp;
        @(negedge i_clk); i_reset = 1'b0; #1;
        @(negedge i_clk); i_reset = 1'b1; #1;
        set_fetch(32'h400);
        for (int i = 0; i < 10; i++) begin
            set_res(32'h400, 1'b1, 1'b0, 1'b1, 32'h600, 1'b1, (i % 3 == 0 && i > 0) ? 32'h404 : 32'h600);
            tick();
        end
`ifdef BRANCH_PREDICTOR_PERF_CNT_EN
        exp_br = 32'd10; exp_mp = 32'd3;
`else
        exp_br = 32'd0;  exp_mp = 32'd0;
`endif
        n_tests++; if (bus1.o_br_count !== exp_br) begin n_fail++; $display("FAIL perf_br: got %0d want %0d", bus1.o_br_count, exp_br); end
        n_tests++; if (bus1.o_mispred_count !== exp_mp) begin n_fail++; $display("FAIL perf_mp: got %0d want %0d", bus1.o_mispred_count, exp_mp); end
        n_tests++; if (bus1.o_pred_taken !== 1'b1 || bus1.o_pred_target !== 32'h600) begin n_fail++; $display("FAIL perf_trained: got %0h/%h want 1/00000600", bus1.o_pred_taken, bus1.o_pred_target); end
        set_res(32'h400, 1'b1, 1'b0, 1'b1, 32'h600, 1'b0, 32'h404);
        i_reset = 1'b0;
        #1;
        n_tests++; if (bus1.o_br_count !== 32'd0 || bus1.o_mispred_count !== 32'd0) begin n_fail++; $display("FAIL midreset_perf: got %0d/%0d want 0/0", bus1.o_br_count, bus1.o_mispred_count); end
        n_tests++; if (bus1.o_pred_taken !== 1'b0 || bus1.o_pred_target !== 32'h404) begin n_fail++; $display("FAIL midreset_table: got %0h/%h want 0/00000404", bus1.o_pred_taken, bus1.o_pred_target); end
        tick();
        @(negedge i_clk); i_reset = 1'b1; #1;
        n_tests++; if (bus1.o_mispred !== 1'b0 || bus1.o_pred_taken !== 1'b0) begin n_fail++; $display("FAIL midreset_discard: got %0h/%0h want 0/0", bus1.o_mispred, bus1.o_pred_taken); end
    endtask

    initial begin
        test_reset();
        test_train_taken();
        test_counter();
        test_alias();
        test_uncond();
        test_nonctrl();
        test_mode0();
        test_perf();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
